// File: rtl/player_link_tx_pkg.sv
// link_pkg: shared types and constants for the player-to-player link.
//   HDR_DEFAULT   : header nibble that the receiver uses to find frame alignment
//   BYTES_PER_MSG : number of UART bytes in one status message
//   link_state_t  : byte-serialiser states
//   msg_state_t   : message-level sequencing states
//   link_msg_t    : status snapshot {ready, hit, cords}
//   msg_byte()    : builds one message byte from a snapshot
package link_pkg;

    localparam logic [3:0] HDR_DEFAULT   = 4'hA;
    localparam int         BYTES_PER_MSG = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } link_state_t;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_SEND,
        MSG_DONE
    } msg_state_t;

    typedef struct packed {
        logic       ready;
        logic       hit;
        logic [7:0] cords;
    } link_msg_t;

    // byte 0 = {hdr, 2'b00, ready, hit}, byte 1 = cords
    function automatic logic [7:0] msg_byte(input link_msg_t m,
                                            input logic [3:0] hdr,
                                            input logic       idx);
        return idx ? m.cords : {hdr, 2'b00, m.ready, m.hit};
    endfunction

endpackage

// File: rtl/player_link_tx_if.sv
// player_link_tx_if: status inputs from the local game FSM and the serial
// line/status outputs of the link transmitter.
//   ready_in, hit_in, cords_in : current local status
//   resend_req                 : one-cycle request to retransmit the status
//   tx                         : UART line, idle high
//   busy                       : message in flight
//   sent                       : one-cycle pulse when a message completes
// master = game side, slave = transmitter.
interface player_link_tx_if;

    logic       ready_in;
    logic       hit_in;
    logic [7:0] cords_in;
    logic       resend_req;
    logic       tx;
    logic       busy;
    logic       sent;

    modport master (
        output ready_in, hit_in, cords_in, resend_req,
        input  tx, busy, sent
    );

    modport slave (
        input  ready_in, hit_in, cords_in, resend_req,
        output tx, busy, sent
    );

endinterface

// File: rtl/player_link_tx_uart_byte.sv
// link_uart_byte_tx: serialises one byte as start, 8 data bits LSB first,
// optional even parity, stop. Every bit lasts CLKS_PER_BIT cycles.
// A start request accepted in cycle N puts the start bit on tx from N+1.
// byte_done is high in the last cycle of the stop bit; a start request in
// that same cycle chains the next byte with no idle gap.
// Build option: LINK_PARITY_EN inserts the PARITY bit (8E1), else 8N1.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request to send data (taken in IDLE or on byte_done)
//   data      : byte to send, sampled with start
//   tx        : serial output
//   byte_done : last cycle of the stop bit
//
// state  | meaning
// IDLE   | line idle, waiting for start
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | even parity over the data bits
// STOP   | stop bit (1)
module link_uart_byte_tx
    import link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    link_state_t state, state_nxt;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bit;
    logic        bit_tc;
    logic        load;

    assign bit_tc = (clk_cnt == 16'd0);
    assign load   = start && ((state == IDLE) || ((state == STOP) && bit_tc));

    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = START;
            START:  if (bit_tc) state_nxt = DATA;
            DATA: begin
                if (bit_tc && (bit_idx == 3'd7)) begin
`ifdef LINK_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: if (bit_tc) state_nxt = STOP;
            STOP: begin
                if (bit_tc) begin
                    byte_done = 1'b1;
                    state_nxt = start ? START : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The divider reloads on every state change and at each bit boundary,
    // so bit timing never accumulates error across the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= BIT_RELOAD;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) || (state_nxt != state) || bit_tc) begin
                clk_cnt <= BIT_RELOAD;
            end else begin
                clk_cnt <= clk_cnt - 16'd1;
            end
            if (load) begin
                shreg   <= data;
                par_bit <= ^data;
            end else if ((state == DATA) && bit_tc) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state != DATA) && (state_nxt == DATA)) begin
                bit_idx <= 3'd0;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PARITY:  tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/player_link_tx.sv
// player_link_tx: transmit end of the player-to-player link. Watches the
// local status {ready, hit, cords} and sends it as a 2-byte UART message
// whenever it differs from the last message sent, or on resend_req.
// Build option: LINK_PARITY_EN (8E1 framing, handled in link_uart_byte_tx).
//   clk, rst : clock, synchronous active-high reset
//   link     : player_link_tx_if.slave (status in, tx/busy/sent out)
// Parameters: CLKS_PER_BIT (2..65535), HDR (byte-0 header nibble).
//
// state    | meaning
// MSG_IDLE | compare status with last_sent, wait for trigger
// MSG_SEND | bytes of the message in flight
// MSG_DONE | one cycle: sent pulse, line idle
module player_link_tx
    import link_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 564,
    parameter logic [3:0] HDR          = HDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    player_link_tx_if.slave  link
);

    localparam logic LAST_IDX = 1'(BYTES_PER_MSG - 1);

    msg_state_t state, state_nxt;
    link_msg_t  snap;
    link_msg_t  msg;
    link_msg_t  last_sent;
    logic       pending;
    logic       byte_idx;
    logic       trigger;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       byte_done;
    logic       tx_ser;

    assign snap = {link.ready_in, link.hit_in, link.cords_in};

    always_comb begin
        state_nxt  = state;
        trigger    = 1'b0;
        byte_start = 1'b0;
        byte_data  = msg_byte(msg, HDR, byte_idx);
        case (state)
            MSG_IDLE: begin
                trigger = (snap != last_sent) || link.resend_req || pending;
                if (trigger) begin
                    // byte 0 comes straight from the live snapshot; msg is
                    // only valid from the next cycle
                    byte_start = 1'b1;
                    byte_data  = msg_byte(snap, HDR, 1'b0);
                    state_nxt  = MSG_SEND;
                end
            end
            MSG_SEND: begin
                if (byte_done) begin
                    if (byte_idx == LAST_IDX) begin
                        state_nxt = MSG_DONE;
                    end else begin
                        byte_start = 1'b1;
                        byte_data  = msg_byte(msg, HDR, byte_idx + 1'b1);
                    end
                end
            end
            MSG_DONE: state_nxt = MSG_IDLE;
            default:  state_nxt = MSG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MSG_IDLE;
            msg       <= '0;
            last_sent <= '0;
            pending   <= 1'b0;
            byte_idx  <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == MSG_IDLE) && trigger) begin
                msg       <= snap;
                last_sent <= snap;
                byte_idx  <= 1'b0;
                pending   <= 1'b0;
            end else begin
                // any number of requests outside IDLE collapse to one resend
                if ((state != MSG_IDLE) && link.resend_req) begin
                    pending <= 1'b1;
                end
                if ((state == MSG_SEND) && byte_done && (byte_idx != LAST_IDX)) begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    link_uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (byte_start),
        .data      (byte_data),
        .tx        (tx_ser),
        .byte_done (byte_done)
    );

    assign link.tx   = tx_ser;
    assign link.busy = (state == MSG_SEND);
    assign link.sent = (state == MSG_DONE);

endmodule
